// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one I-cache request in flight and
// feeds the IF/ID register, parking a response in a one-entry buffer while decode stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        intr_flag_i,
    input  logic [31:0] pc_intr_i,
    input  logic        is_mret_i,
    input  logic [31:0] pc_mret_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_valid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_hit_i,
    output logic [31:0] inst_d_o,
    output logic [31:0] pc_d_o,
    output logic [31:0] pc4_d_o,
    output logic        hit_d_o,
    output logic        valid_d_o,
    output logic        fetch_stall_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] INST_BYTES = 32'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        hold_hit_q, hold_hit_d;
    logic [31:0] ifid_inst_q, ifid_inst_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic        ifid_hit_q, ifid_hit_d;
    logic        ifid_valid_q, ifid_valid_d;

    logic        redirect;
    logic [31:0] redirect_pc;
    logic        delivered;

    always_comb begin
        redirect = intr_flag_i | is_mret_i | br_taken_i;
        if (intr_flag_i) begin
            redirect_pc = pc_intr_i;
        end else if (is_mret_i) begin
            redirect_pc = pc_mret_i;
        end else begin
            redirect_pc = br_pc_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        hold_hit_d   = hold_hit_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_hit_d   = ifid_hit_q;
        ifid_valid_d = ifid_valid_q;
        delivered    = 1'b0;

        // Flush and bubble both leave a NOP marked invalid in IF/ID.
        if (redirect || (enable_i && state_q != S_HOLD &&
                         !(state_q == S_FETCH && imem_valid_i))) begin
            ifid_inst_d  = NOP_INST;
            ifid_pc_d    = 32'd0;
            ifid_pc4_d   = 32'd0;
            ifid_hit_d   = 1'b0;
            ifid_valid_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                    if (!imem_valid_i) begin
                        // The in-flight request cannot be aborted; remember it.
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
                end else if (imem_valid_i) begin
                    pc_d = pc_q + INST_BYTES;
                    if (enable_i) begin
                        ifid_inst_d  = imem_rdata_i;
                        ifid_pc_d    = pc_q;
                        ifid_pc4_d   = pc_q + INST_BYTES;
                        ifid_hit_d   = imem_hit_i;
                        ifid_valid_d = 1'b1;
                        delivered    = 1'b1;
                    end else begin
                        hold_inst_d = imem_rdata_i;
                        hold_pc_d   = pc_q;
                        hold_hit_d  = imem_hit_i;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_FETCH;
                end else if (enable_i) begin
                    ifid_inst_d  = hold_inst_q;
                    ifid_pc_d    = hold_pc_q;
                    ifid_pc4_d   = hold_pc_q + INST_BYTES;
                    ifid_hit_d   = hold_hit_q;
                    ifid_valid_d = 1'b1;
                    delivered    = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    pc_d = redirect_pc;
                end
                // Once the stale response lands it is dropped and fetching resumes.
                if (imem_valid_i) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= 32'd0;
            hold_inst_q  <= NOP_INST;
            hold_pc_q    <= 32'd0;
            hold_hit_q   <= 1'b0;
            ifid_inst_q  <= NOP_INST;
            ifid_pc_q    <= 32'd0;
            ifid_pc4_q   <= 32'd0;
            ifid_hit_q   <= 1'b0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            hold_hit_q   <= hold_hit_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_hit_q   <= ifid_hit_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign imem_req_o    = (state_q != S_HOLD);
    assign imem_addr_o   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign fetch_stall_o = enable_i & ~redirect & ~delivered;

    assign inst_d_o  = ifid_inst_q;
    assign pc_d_o    = ifid_pc_q;
    assign pc4_d_o   = ifid_pc4_q;
    assign hit_d_o   = ifid_hit_q;
    assign valid_d_o = ifid_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table plus hand sequences
// for PC wrap-around and reset taken while a response is parked.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam int          NROWS = 25;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        intr_flag_i;
    logic [31:0] pc_intr_i;
    logic        is_mret_i;
    logic [31:0] pc_mret_i;
    logic        br_taken_i;
    logic [31:0] br_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_valid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_hit_i;
    logic [31:0] inst_d_o;
    logic [31:0] pc_d_o;
    logic [31:0] pc4_d_o;
    logic        hit_d_o;
    logic        valid_d_o;
    logic        fetch_stall_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    if_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(32'h0000_0013)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .intr_flag_i  (intr_flag_i),
        .pc_intr_i    (pc_intr_i),
        .is_mret_i    (is_mret_i),
        .pc_mret_i    (pc_mret_i),
        .br_taken_i   (br_taken_i),
        .br_pc_i      (br_pc_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_valid_i (imem_valid_i),
        .imem_rdata_i (imem_rdata_i),
        .imem_hit_i   (imem_hit_i),
        .inst_d_o     (inst_d_o),
        .pc_d_o       (pc_d_o),
        .pc4_d_o      (pc4_d_o),
        .hit_d_o      (hit_d_o),
        .valid_d_o    (valid_d_o),
        .fetch_stall_o(fetch_stall_o)
    );

    typedef struct {
        logic        en;
        logic        intr;
        logic        mret;
        logic        br;
        logic [31:0] br_pc;
        logic        val;
        logic        hit;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_stall;
        logic        exp_v;
        logic [31:0] exp_pc;
        logic        exp_hit;
    } vec_t;

    vec_t tbl [NROWS];

    function automatic vec_t mk(
        input logic en, input logic intr, input logic mret, input logic br,
        input logic [31:0] br_pc, input logic val, input logic hit,
        input logic exp_req, input logic [31:0] exp_addr, input logic exp_stall,
        input logic exp_v, input logic [31:0] exp_pc, input logic exp_hit);
        vec_t v;
        v.en = en; v.intr = intr; v.mret = mret; v.br = br; v.br_pc = br_pc;
        v.val = val; v.hit = hit; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_stall = exp_stall; v.exp_v = exp_v; v.exp_pc = exp_pc; v.exp_hit = exp_hit;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle from the vector; responses carry addr^KEY as data.
    task automatic run_row(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("row%0d", idx);
        enable_i     = v.en;
        intr_flag_i  = v.intr;
        is_mret_i    = v.mret;
        br_taken_i   = v.br;
        br_pc_i      = v.br_pc;
        imem_valid_i = v.val;
        imem_hit_i   = v.hit;
        imem_rdata_i = v.exp_addr ^ KEY;
        #1;
        chk({tag, ".req"}, {31'd0, imem_req_o}, {31'd0, v.exp_req});
        if (v.exp_req) chk({tag, ".addr"}, imem_addr_o, v.exp_addr);
        chk({tag, ".stall"}, {31'd0, fetch_stall_o}, {31'd0, v.exp_stall});
        @(posedge clk_i);
        #1;
        chk({tag, ".valid"}, {31'd0, valid_d_o}, {31'd0, v.exp_v});
        if (v.exp_v) begin
            chk({tag, ".inst"}, inst_d_o, v.exp_pc ^ KEY);
            chk({tag, ".pc"}, pc_d_o, v.exp_pc);
            chk({tag, ".pc4"}, pc4_d_o, v.exp_pc + 32'd4);
            chk({tag, ".hit"}, {31'd0, hit_d_o}, {31'd0, v.exp_hit});
        end else begin
            chk({tag, ".inst"}, inst_d_o, NOP);
        end
        $display("cycle %s en=%0b redir=%0b%0b%0b val=%0b addr=%h -> pc_d=%h inst_d=%h v=%0b",
                 tag, v.en, v.intr, v.mret, v.br, v.val, imem_addr_o, pc_d_o, inst_d_o, valid_d_o);
    endtask

    initial begin
        //            en i m b br_pc         val hit req addr          stl v pc            hit
        tbl[0]  = mk(1, 0,0,0, 32'h0,         1, 1,  1, 32'h0,         0,  1, 32'h0,         1);
        tbl[1]  = mk(1, 0,0,0, 32'h0,         1, 0,  1, 32'h4,         0,  1, 32'h4,         0);
        tbl[2]  = mk(1, 0,0,0, 32'h0,         1, 1,  1, 32'h8,         0,  1, 32'h8,         1);
        tbl[3]  = mk(1, 0,0,0, 32'h0,         1, 1,  1, 32'hC,         0,  1, 32'hC,         1);
        tbl[4]  = mk(1, 0,0,0, 32'h0,         0, 0,  1, 32'h10,        1,  0, 32'h0,         0);
        tbl[5]  = mk(1, 0,0,0, 32'h0,         0, 0,  1, 32'h10,        1,  0, 32'h0,         0);
        tbl[6]  = mk(1, 0,0,0, 32'h0,         1, 0,  1, 32'h10,        0,  1, 32'h10,        0);
        tbl[7]  = mk(0, 0,0,0, 32'h0,         1, 1,  1, 32'h14,        0,  1, 32'h10,        0);
        tbl[8]  = mk(0, 0,0,0, 32'h0,         0, 0,  0, 32'h0,         0,  1, 32'h10,        0);
        tbl[9]  = mk(1, 0,0,0, 32'h0,         0, 0,  0, 32'h0,         0,  1, 32'h14,        1);
        tbl[10] = mk(1, 0,0,0, 32'h0,         1, 1,  1, 32'h18,        0,  1, 32'h18,        1);
        tbl[11] = mk(1, 0,0,0, 32'h0,         1, 1,  1, 32'h1C,        0,  1, 32'h1C,        1);
        tbl[12] = mk(1, 0,0,0, 32'h0,         0, 0,  1, 32'h20,        1,  0, 32'h0,         0);
        tbl[13] = mk(1, 0,0,1, 32'h200,       0, 0,  1, 32'h20,        0,  0, 32'h0,         0);
        tbl[14] = mk(1, 0,0,0, 32'h0,         0, 0,  1, 32'h20,        1,  0, 32'h0,         0);
        tbl[15] = mk(1, 0,0,0, 32'h0,         1, 0,  1, 32'h20,        1,  0, 32'h0,         0);
        tbl[16] = mk(1, 0,0,0, 32'h0,         1, 1,  1, 32'h200,       0,  1, 32'h200,       1);
        tbl[17] = mk(1, 1,1,1, 32'h200,       1, 1,  1, 32'h204,       0,  0, 32'h0,         0);
        tbl[18] = mk(1, 0,0,0, 32'h0,         1, 0,  1, 32'h80,        0,  1, 32'h80,        0);
        tbl[19] = mk(0, 0,1,1, 32'h200,       0, 0,  1, 32'h84,        0,  0, 32'h0,         0);
        tbl[20] = mk(1, 0,0,0, 32'h0,         1, 0,  1, 32'h84,        1,  0, 32'h0,         0);
        tbl[21] = mk(1, 0,0,1, 32'h300,       0, 0,  1, 32'h44,        0,  0, 32'h0,         0);
        tbl[22] = mk(1, 0,0,1, 32'h400,       0, 0,  1, 32'h44,        0,  0, 32'h0,         0);
        tbl[23] = mk(1, 0,0,0, 32'h0,         1, 0,  1, 32'h44,        1,  0, 32'h0,         0);
        tbl[24] = mk(1, 0,0,0, 32'h0,         1, 1,  1, 32'h400,       0,  1, 32'h400,       1);

        rst_ni = 1'b0; enable_i = 1'b1; intr_flag_i = 1'b0; is_mret_i = 1'b0;
        br_taken_i = 1'b0; br_pc_i = 32'h0; pc_intr_i = 32'h80; pc_mret_i = 32'h44;
        imem_valid_i = 1'b0; imem_rdata_i = 32'h0; imem_hit_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset.inst", inst_d_o, NOP);
        chk("reset.pc", pc_d_o, 32'h0);
        chk("reset.pc4", pc4_d_o, 32'h0);
        chk("reset.hit", {31'd0, hit_d_o}, 32'd0);
        chk("reset.valid", {31'd0, valid_d_o}, 32'd0);
        rst_ni = 1'b1;
        #1;
        chk("reset.req", {31'd0, imem_req_o}, 32'd1);
        chk("reset.addr", imem_addr_o, 32'h0);
        $display("cycle reset done addr=%h inst_d=%h", imem_addr_o, inst_d_o);

        for (int i = 0; i < NROWS; i++) begin
            run_row(i, tbl[i]);
        end

        // PC wrap: redirect to the last word, fetch it, then expect address 0.
        run_row(100, mk(1, 0,0,1, 32'hFFFF_FFFC, 1, 1, 1, 32'h404, 0, 0, 32'h0, 0));
        run_row(101, mk(1, 0,0,0, 32'h0, 1, 1, 1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC, 1));
        chk("wrap.pc4", pc4_d_o, 32'h0);

        // Park the response at 0 in HOLD, then reset while parked.
        run_row(102, mk(0, 0,0,0, 32'h0, 1, 0, 1, 32'h0, 0, 1, 32'hFFFF_FFFC, 1));
        rst_ni = 1'b0; enable_i = 1'b0; imem_valid_i = 1'b0;
        #1;
        chk("hold.req", {31'd0, imem_req_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk("rst_hold.valid", {31'd0, valid_d_o}, 32'd0);
        chk("rst_hold.inst", inst_d_o, NOP);
        chk("rst_hold.pc", pc_d_o, 32'h0);
        #1;
        chk("rst_hold.req", {31'd0, imem_req_o}, 32'd1);
        chk("rst_hold.addr", imem_addr_o, 32'h0);
        $display("cycle reset-in-hold addr=%h valid_d=%0b", imem_addr_o, valid_d_o);
        run_row(103, mk(1, 0,0,0, 32'h0, 1, 1, 1, 32'h0, 0, 1, 32'h0, 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
